gen_stream_mux: RTL and testbench
=================================

Name: gen_stream_mux

Overview:
- Parametrised successor to the team's generate-case 4:1 selector. Selects one of N_CH input streams onto a single registered output stream with valid/ready handshakes.
- Selection policy is chosen at elaboration by a generate-case on MODE: static select, fixed priority, or round-robin.
- Sits between multiple producers and one consumer. Also serves as a regression vehicle for generate-case, parameter and flattened-bus elaboration.

Parameters:
- WIDTH, 2, data bits per channel.
- N_CH, 4, number of input channels (2..16).
- SEL_W, 2, width of sel and out_chan; must satisfy 2**SEL_W >= N_CH.
- MODE, 0, policy: 0 = static sel, 1 = fixed priority (lowest index wins), 2 = round-robin. Any other value behaves as MODE 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational).
- in_data  input  N_CH*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  N_CH  per-channel end-of-packet flag.
- sel  input  SEL_W  channel select; used only when MODE = 0.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_data  output  WIDTH  registered output data.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_last  output  1  registered copy of the accepted in_last.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, out_last = 0, round-robin pointer = N_CH-1 (so channel 0 has first priority), lock = clear.
- Load condition: load = !out_valid || out_ready. One-entry output register. Full throughput: one beat per cycle while out_ready = 1.
- Arbitration is combinational and evaluated every cycle. grant is one-hot or zero.
- in_ready[i] = load && grant[i].
- Transfer on input i occurs when in_valid[i] && in_ready[i].
- On transfer: the output register loads data, index and last from the granted channel, and out_valid = 1 on the next cycle.
- If load is true and there is no transfer, out_valid = 0 on the next cycle.
- If load is false, all output registers hold. The output register never changes while out_valid && !out_ready.
- Latency: a beat accepted in cycle t appears on the outputs in cycle t+1.
- MODE 0 (static):
  - grant[sel] = in_valid[sel]; all other channels get no grant.
  - sel >= N_CH selects channel N_CH-1 (default arm).
  - A sel change takes effect in the same cycle.
- MODE 1 (priority): the lowest-index channel with valid set is granted.
- MODE 2 (round-robin):
  - Search starts at pointer+1 and wraps modulo N_CH. The first channel with valid set is granted.
  - The pointer updates to the granted index only on a transfer; it holds otherwise.
- No valid input -> grant = 0; all in_ready = 0.
- Backpressure (out_valid && !out_ready) forces all in_ready = 0, including channels with valid set.
- Simultaneous output drain and new accept in the same cycle is permitted and required (back-to-back beats).
- Reset asserted mid-stream: the beat held in the output register is discarded, outputs take their reset values next cycle, and in_ready is 0 during the reset cycle.

Optional Feature:
- Macro: GEN_STREAM_MUX_LOCK_EN.
- With the macro defined (packet lock):
  - Accepting a beat from channel c with in_last[c] = 0 sets lock to c.
  - While locked, only channel c may be granted. Other channels get no grant even if c is not valid, in every MODE. In MODE 0 the sel input is ignored while locked.
  - Accepting a beat from c with in_last[c] = 1 clears the lock. The next arbitration then follows MODE.
  - In MODE 2 the pointer still updates per transfer.
- Without the macro:
  - in_last is only forwarded to out_last and has no effect on arbitration.
  - No lock register is built.

Test Plan:
- MODE 0, N_CH = 4, WIDTH = 2, data = {3,2,1,0}, all valid, out_ready = 1, sel stepped 0,1,2,3 -> out_data = 0,1,2,3 one cycle after each sel; out_chan matches sel.
- MODE 0, N_CH = 3, sel = 3 -> channel 2 granted, out_chan = 2 (default arm).
- MODE 1, valid = 4'b1010 -> channel 1 granted every cycle; channel 3 in_ready stays 0.
- MODE 2, all four channels valid for 8 cycles, out_ready = 1 -> out_chan sequence 0,1,2,3,0,1,2,3. After reset, with only channel 2 valid -> the first grant is channel 2.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data and out_chan stable, all in_ready = 0. On release -> drain and new accept in the same cycle, no beat lost or duplicated.
- LOCK_EN, MODE 2: channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is valid throughout -> out_chan = 1,1,1 then 0. Reset mid-packet -> out_valid = 0 and lock cleared next cycle.

Source files
------------

// File: rtl/gen_stream_mux.sv
// N_CH:1 stream multiplexer with a registered one-entry output stage and a
// policy chosen by MODE. Define GEN_STREAM_MUX_LOCK_EN to keep a channel granted until its last beat.
module gen_stream_mux #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned MODE  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_last,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_last
);

  localparam int unsigned LAST_CH = N_CH - 1;

  logic              load;
  logic              xfer;
  logic [N_CH-1:0]   pol_grant;
  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  gidx;
  logic [WIDTH-1:0]  g_data;
  logic              g_last;

  // Isolate the lowest set bit of a request vector.
  function automatic logic [N_CH-1:0] lowest_set(input logic [N_CH-1:0] v);
    logic [N_CH-1:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  generate
    case (MODE)
      0: begin : g_static
        logic [SEL_W-1:0] sel_eff;
        // Out-of-range selects fall back to the highest channel.
        assign sel_eff = (32'(sel) >= N_CH) ? SEL_W'(LAST_CH) : sel;
        always_comb begin
          pol_grant = '0;
          for (int i = 0; i < N_CH; i++) begin
            pol_grant[i] = in_valid[i] && (sel_eff == SEL_W'(i));
          end
        end
      end
      2: begin : g_rr
        logic [SEL_W-1:0] rr_ptr;
        logic [N_CH-1:0]  upper;
        logic [N_CH-1:0]  hi_req;
        logic             unused_sel;
        assign unused_sel = ^sel;

        always_ff @(posedge clk) begin
          if (reset) begin
            rr_ptr <= SEL_W'(LAST_CH);
          end else if (xfer) begin
            rr_ptr <= gidx;
          end
        end

        always_comb begin
          upper = '0;
          for (int i = 0; i < N_CH; i++) begin
            upper[i] = (SEL_W'(i) > rr_ptr);
          end
        end

        // Channels above the pointer win first; otherwise wrap to the bottom.
        assign hi_req    = in_valid & upper;
        assign pol_grant = (|hi_req) ? lowest_set(hi_req) : lowest_set(in_valid);
      end
      default: begin : g_prio
        logic unused_sel;
        assign unused_sel = ^sel;
        assign pol_grant  = lowest_set(in_valid);
      end
    endcase
  endgenerate

`ifdef GEN_STREAM_MUX_LOCK_EN
  logic             lock_vld;
  logic [SEL_W-1:0] lock_ch;
  logic [N_CH-1:0]  lock_mask;

  // A non-final beat pins arbitration to its channel until the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_ch  <= '0;
    end else if (xfer) begin
      lock_vld <= !g_last;
      lock_ch  <= gidx;
    end
  end

  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      lock_mask[i] = (lock_ch == SEL_W'(i));
    end
  end

  assign grant = lock_vld ? (in_valid & lock_mask) : pol_grant;
`else
  assign grant = pol_grant;
`endif

  assign load     = !out_valid || out_ready;
  assign in_ready = (load && !reset) ? grant : '0;
  assign xfer     = load && !reset && (|grant);

  // Grant is one-hot or zero, so an OR-reduction acts as the mux.
  always_comb begin
    gidx   = '0;
    g_data = '0;
    g_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        gidx   = gidx | SEL_W'(i);
        g_data = g_data | in_data[i*WIDTH +: WIDTH];
        g_last = g_last | in_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= g_data;
        out_chan <= gidx;
        out_last <= g_last;
      end
    end
  end

endmodule

// File: tb/tb_gen_stream_mux.sv
// Scoreboard bench for gen_stream_mux: four instances (static, priority,
// round-robin, and a 3-channel static) share one randomized stimulus stream.
module tb_gen_stream_mux;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [7:0] in_data;
  logic [1:0] sel;
  logic       out_ready;

  logic [3:0] rdy0, rdy1, rdy2;
  logic [2:0] rdy3;
  logic       ov [NI];
  logic [1:0] od [NI];
  logic [1:0] oc [NI];
  logic       ol [NI];

  always #5 clk = ~clk;

  gen_stream_mux #(.WIDTH(2), .N_CH(4), .SEL_W(2), .MODE(0)) u_static (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .sel(sel), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_chan(oc[0]), .out_last(ol[0]));

  gen_stream_mux #(.WIDTH(2), .N_CH(4), .SEL_W(2), .MODE(1)) u_prio (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .sel(sel), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_chan(oc[1]), .out_last(ol[1]));

  gen_stream_mux #(.WIDTH(2), .N_CH(4), .SEL_W(2), .MODE(2)) u_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_last(in_last), .sel(sel), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_chan(oc[2]), .out_last(ol[2]));

  gen_stream_mux #(.WIDTH(2), .N_CH(3), .SEL_W(2), .MODE(0)) u_static3 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2:0]), .in_ready(rdy3), .in_data(in_data[5:0]),
    .in_last(in_last[2:0]), .sel(sel), .out_valid(ov[3]), .out_ready(out_ready),
    .out_data(od[3]), .out_chan(oc[3]), .out_last(ol[3]));

  int mode_of [NI] = '{0, 1, 2, 0};
  int nch_of  [NI] = '{4, 4, 4, 3};

  // Reference state: queued beats {last, chan, data}, rr pointer, packet lock.
  logic [4:0] sbq [NI][$];
  int         ptr [NI];
  bit         lk_v [NI];
  int         lk_c [NI];
  bit         zero_chk [NI];
  bit         mon_en = 1'b0;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, m, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] get_rdy(input int m);
    case (m)
      0:       return rdy0;
      1:       return rdy1;
      2:       return rdy2;
      default: return {1'b0, rdy3};
    endcase
  endfunction

  // Expected granted channel from the policy rules, or -1 for none.
  function automatic int model_grant(input int m);
    int n;
    int s;
    int c;
    n = nch_of[m];
    if (lk_v[m]) return in_valid[lk_c[m]] ? lk_c[m] : -1;
    case (mode_of[m])
      0: begin
        s = int'(sel);
        if (s >= n) s = n - 1;
        return in_valid[s] ? s : -1;
      end
      2: begin
        for (int k = 1; k <= n; k++) begin
          c = (ptr[m] + k) % n;
          if (in_valid[c]) return c;
        end
        return -1;
      end
      default: begin
        for (int i = 0; i < n; i++) if (in_valid[i]) return i;
        return -1;
      end
    endcase
  endfunction

  // Drive one cycle of inputs, check in_ready, and update the scoreboard.
  task automatic apply(input logic r, input logic [3:0] v, input logic [7:0] d,
                       input logic [3:0] l, input logic [1:0] s, input logic ordy);
    int   g;
    bit   load;
    logic [4:0] b;
    @(negedge clk);
    reset = r; in_valid = v; in_data = d; in_last = l; sel = s; out_ready = ordy;
    mon_en = 1'b1;
    #1;
    for (int m = 0; m < NI; m++) begin
      load = (sbq[m].size() == 0) || out_ready;
      g    = reset ? -1 : model_grant(m);
      check("in_ready", m, 32'(get_rdy(m)), (load && g >= 0) ? (32'd1 << g) : 32'd0);
      if (reset) begin
        sbq[m].delete();
        ptr[m]      = nch_of[m] - 1;
        lk_v[m]     = 1'b0;
        zero_chk[m] = 1'b1;
      end else begin
        if (sbq[m].size() > 0 && out_ready) void'(sbq[m].pop_front());
        if (load && g >= 0) begin
          b = {in_last[g], 2'(g), in_data[g*2 +: 2]};
          sbq[m].push_back(b);
          if (mode_of[m] == 2) ptr[m] = g;
`ifdef GEN_STREAM_MUX_LOCK_EN
          if (in_last[g]) lk_v[m] = 1'b0;
          else begin
            lk_v[m] = 1'b1;
            lk_c[m] = g;
          end
`endif
        end
      end
    end
  endtask

  // Monitor: compare registered outputs with the scoreboard head after each edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      for (int m = 0; m < NI; m++) begin
        check("out_valid", m, 32'(ov[m]), 32'(sbq[m].size() != 0));
        if (ov[m] === 1'b1 && sbq[m].size() != 0) begin
          check("out_data", m, 32'(od[m]), 32'(sbq[m][0][1:0]));
          check("out_chan", m, 32'(oc[m]), 32'(sbq[m][0][3:2]));
          check("out_last", m, 32'(ol[m]), 32'(sbq[m][0][4]));
        end
        if (zero_chk[m]) begin
          check("rst_data", m, 32'(od[m]), 32'd0);
          check("rst_chan", m, 32'(oc[m]), 32'd0);
          check("rst_last", m, 32'(ol[m]), 32'd0);
          zero_chk[m] = 1'b0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; in_last = '0; sel = '0; out_ready = 1'b0;
    for (int m = 0; m < NI; m++) begin
      ptr[m] = nch_of[m] - 1; lk_v[m] = 1'b0; lk_c[m] = 0; zero_chk[m] = 1'b0;
    end
    apply(1'b1, 4'h0, 8'h00, 4'h0, 2'd0, 1'b1);
    apply(1'b1, 4'h0, 8'h00, 4'h0, 2'd0, 1'b1);

    // Static select stepping with data {3,2,1,0}, then sel = 3 for the 3-channel default arm.
    for (int s = 0; s < 4; s++) apply(1'b0, 4'hF, 8'b11_10_01_00, 4'hF, 2'(s), 1'b1);
    apply(1'b0, 4'hF, 8'b11_10_01_00, 4'hF, 2'd3, 1'b1);

    // Priority with channels 1 and 3 valid.
    for (int i = 0; i < 4; i++) apply(1'b0, 4'b1010, 8'($urandom), 4'hF, 2'd1, 1'b1);

    // Round-robin from reset with all channels valid for 8 cycles.
    apply(1'b1, 4'h0, 8'h00, 4'h0, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) apply(1'b0, 4'hF, 8'($urandom), 4'hF, 2'd2, 1'b1);

    // After reset, only channel 2 valid.
    apply(1'b1, 4'h0, 8'h00, 4'h0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) apply(1'b0, 4'b0100, 8'($urandom), 4'hF, 2'd2, 1'b1);

    // Backpressure for 3 cycles then release.
    apply(1'b0, 4'hF, 8'($urandom), 4'hF, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) apply(1'b0, 4'hF, 8'($urandom), 4'hF, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 4'hF, 8'($urandom), 4'hF, 2'd1, 1'b1);

    // Channel 1 sends a 3-beat packet while channel 0 stays valid.
    apply(1'b1, 4'h0, 8'h00, 4'h0, 2'd0, 1'b1);
    apply(1'b0, 4'b0010, 8'b00_00_01_10, 4'b0000, 2'd1, 1'b1);
    apply(1'b0, 4'b0011, 8'b00_00_10_10, 4'b0000, 2'd1, 1'b1);
    apply(1'b0, 4'b0011, 8'b00_00_11_10, 4'b0010, 2'd1, 1'b1);
    apply(1'b0, 4'b0001, 8'b00_00_00_11, 4'b0001, 2'd1, 1'b1);
    // Mid-packet reset.
    apply(1'b0, 4'b0010, 8'b00_00_01_00, 4'b0000, 2'd1, 1'b1);
    apply(1'b1, 4'b0011, 8'b00_00_10_01, 4'b0000, 2'd1, 1'b1);
    apply(1'b0, 4'b0011, 8'b00_00_11_01, 4'b0011, 2'd0, 1'b1);
    apply(1'b0, 4'b0011, 8'b00_00_11_01, 4'b0011, 2'd0, 1'b1);

    // Randomized traffic with occasional resets and backpressure.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 99) == 0), 4'($urandom), 8'($urandom), 4'($urandom),
            2'($urandom), ($urandom_range(0, 9) < 7));
    end
    apply(1'b0, 4'h0, 8'h00, 4'h0, 2'd0, 1'b1);
    apply(1'b0, 4'h0, 8'h00, 4'h0, 2'd0, 1'b1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
